// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned REG_AW     = 3;
    localparam int unsigned DATA_W_MAX = 64;

    localparam logic [REG_AW-1:0] REG_ZERO = 3'd0;
    localparam logic [REG_AW-1:0] REG_PC   = 3'd7;

    // Data is carried at the widest supported width; users slice down to DW.
    typedef struct packed {
        logic [REG_AW-1:0]     addr;
        logic [DATA_W_MAX-1:0] data;
    } wr_req_t;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_arb_rr_arb2.sv
// Two-way round-robin grant; priority moves to the other requester after each completed transfer.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    req_id_e prio_q, prio_d;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio_q == REQ_1) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (advance) begin
            prio_d = gnt[1] ? REQ_0 : REQ_1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= REQ_0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_arb.sv
// Arbitrates two register-file write requesters and issues deferred PC (R7) increments.
module regfile_arb
    import regfile_pkg::*;
#(
    parameter int unsigned DW       = 16,
    parameter int unsigned PEND_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [2:0]    req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [2:0]    req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          hold,
    input  logic          pc_inc_req,
    output logic [2:0]    regws,
    output logic [DW-1:0] regw,
    output logic          we,
    output logic          incr_pc,
    output logic [1:0]    pc_pend
);

    localparam logic [2:0] PEND_LIM3 = 3'(PEND_MAX);
    localparam logic [1:0] PEND_LIM2 = 2'(PEND_MAX);

    logic [1:0]    req_vec, gnt;
    logic          xfer, jump;
    wr_req_t       req0_w, req1_w, sel_w;
    logic          unused_sel_data;

    logic          we_q, we_d;
    logic          incr_q, incr_d;
    logic [2:0]    regws_q, regws_d;
    logic [DW-1:0] regw_q, regw_d;
    logic [1:0]    pend_q, pend_d;
    logic [2:0]    pend_sum;
    logic [1:0]    pend_sat;

    // Grants are masked combinationally so ready is low during stall and reset.
    assign req_vec = {req1_valid, req0_valid} & {2{~hold & reset}};

    rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_vec),
        .advance (xfer),
        .gnt     (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign xfer       = |gnt;

    always_comb begin
        req0_w      = '0;
        req0_w.addr = req0_addr;
        req0_w.data = DATA_W_MAX'(req0_data);
        req1_w      = '0;
        req1_w.addr = req1_addr;
        req1_w.data = DATA_W_MAX'(req1_data);
        sel_w       = gnt[1] ? req1_w : req0_w;
    end

    assign unused_sel_data = ^sel_w.data;
    assign jump            = xfer && (sel_w.addr == REG_PC);

    always_comb begin
        we_d    = xfer && (sel_w.addr != REG_ZERO);
        regws_d = regws_q;
        regw_d  = regw_q;
        if (we_d) begin
            regws_d = sel_w.addr;
            regw_d  = sel_w.data[DW-1:0];
        end
    end

    // A same-cycle request joins the pending count before one increment is taken out.
    always_comb begin
        pend_sum = {1'b0, pend_q} + {2'b00, pc_inc_req};
        pend_sat = (pend_sum > PEND_LIM3) ? PEND_LIM2 : pend_sum[1:0];
        incr_d   = 1'b0;
        pend_d   = pend_q;
        if (jump) begin
            pend_d = 2'd0;
        end else if (hold) begin
            pend_d = pend_sat;
        end else if (pend_sat != 2'd0) begin
            incr_d = 1'b1;
            pend_d = pend_sat - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            incr_q  <= 1'b0;
            regws_q <= '0;
            regw_q  <= '0;
            pend_q  <= '0;
        end else begin
            we_q    <= we_d;
            incr_q  <= incr_d;
            regws_q <= regws_d;
            regw_q  <= regw_d;
            pend_q  <= pend_d;
        end
    end

    assign we      = we_q;
    assign incr_pc = incr_q;
    assign regws   = regws_q;
    assign regw    = regw_q;
    assign pc_pend = pend_q;

endmodule

// File: tb/tb_regfile_arb.sv
// Self-checking bench for regfile_arb: directed scenarios plus a randomized run against a behavioural model.
module tb_regfile_arb;

    localparam int DW       = 16;
    localparam int PEND_MAX = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0]    req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic          hold = 1'b0, pc_inc_req = 1'b0;
    logic [2:0]    regws;
    logic [DW-1:0] regw;
    logic          we, incr_pc;
    logic [1:0]    pc_pend;

    int n_total = 0;
    int n_pass  = 0;

    regfile_arb #(.DW(DW), .PEND_MAX(PEND_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .hold       (hold),
        .pc_inc_req (pc_inc_req),
        .regws      (regws),
        .regw       (regw),
        .we         (we),
        .incr_pc    (incr_pc),
        .pc_pend    (pc_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: evaluated at each falling edge, predicts the state after the next rising edge.
    initial begin : compare
        int m_last;
        int m_regws, m_regw, m_pend, cnt, g, addr, data;
        bit m_we, m_incr, prev_hold, jump;
        m_last = 1; m_we = 0; m_incr = 0; m_regws = 0; m_regw = 0; m_pend = 0; prev_hold = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_last = 1; m_we = 0; m_incr = 0; m_regws = 0; m_regw = 0; m_pend = 0; prev_hold = 0;
            end
            check("m_we", we, m_we);
            check("m_regws", regws, m_regws);
            check("m_regw", regw, m_regw);
            check("m_incr", incr_pc, m_incr);
            check("m_pend", pc_pend, m_pend);
            check("m_no_r7_and_incr", we && regws == 3'd7 && incr_pc, 0);
            check("m_no_incr_after_hold", prev_hold && incr_pc, 0);

            g = -1;
            if (reset && !hold) begin
                if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
                else if (req0_valid)          g = 0;
                else if (req1_valid)          g = 1;
            end
            check("m_ready0", req0_ready, g == 0);
            check("m_ready1", req1_ready, g == 1);

            if (reset) begin
                jump = 0;
                m_we = 0;
                if (g >= 0) begin
                    m_last = g;
                    addr = (g == 1) ? int'(req1_addr) : int'(req0_addr);
                    data = (g == 1) ? int'(req1_data) : int'(req0_data);
                    jump = (addr == 7);
                    if (addr != 0) begin
                        m_we = 1; m_regws = addr; m_regw = data;
                    end
                end
                cnt = m_pend + int'(pc_inc_req);
                if (cnt > PEND_MAX) cnt = PEND_MAX;
                m_incr = 0;
                if (jump)          m_pend = 0;
                else if (hold)     m_pend = cnt;
                else if (cnt > 0) begin
                    m_incr = 1; m_pend = cnt - 1;
                end else           m_pend = 0;
                prev_hold = hold;
            end
        end
    end

    initial begin : drive
        bit x0, x1;
        int hold_left;

        // Reset state, with a request already waiting.
        req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'h1234;
        repeat (2) tick();
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_we", we, 0);
        check("rst_regws", regws, 0);
        check("rst_regw", regw, 0);
        check("rst_incr", incr_pc, 0);
        check("rst_pend", pc_pend, 0);

        // Single write; first grant right after reset release.
        reset = 1'b1;
        #1 check("first_grant", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("single_we", we, 1);
        check("single_regws", regws, 3);
        check("single_regw", regw, 16'h1234);
        tick();
        check("single_we_off", we, 0);
        check("single_regws_keep", regws, 3);

        // Zero-register write: accepted but not driven.
        req1_valid = 1'b1; req1_addr = 3'd0; req1_data = 16'hFFFF;
        #1 check("zero_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        check("zero_we", we, 0);
        check("zero_regw_keep", regw, 16'h1234);

        // Contention: pointer advanced by the zero write, so requester 0 goes first.
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h0A01;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h0B02;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_ready0", req0_ready, (k % 2) == 0);
            check("cont_ready1", req1_ready, (k % 2) == 1);
            tick();
            check("cont_we", we, 1);
            check("cont_regws", regws, ((k % 2) == 1) ? 2 : 1);
            check("cont_regw", regw, ((k % 2) == 1) ? 16'h0B02 : 16'h0A01);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Hold with repeated increment requests, then drain.
        hold = 1'b1; pc_inc_req = 1'b1; req0_valid = 1'b1; req0_addr = 3'd4;
        #1 check("hold_ready0", req0_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_incr", incr_pc, 0);
        end
        check("hold_pend_sat", pc_pend, 3);
        req0_valid = 1'b0; hold = 1'b0; pc_inc_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("drain_incr", incr_pc, 1);
            check("drain_pend", pc_pend, 2 - k);
        end
        tick();
        check("drain_done", incr_pc, 0);

        // Jump to R7 overrides pending and same-cycle increments.
        hold = 1'b1; pc_inc_req = 1'b1;
        repeat (2) tick();
        check("jump_pend_pre", pc_pend, 2);
        hold = 1'b0; req0_valid = 1'b1; req0_addr = 3'd7; req0_data = 16'h0040;
        #1 check("jump_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0; pc_inc_req = 1'b0;
        check("jump_we", we, 1);
        check("jump_regws", regws, 7);
        check("jump_regw", regw, 16'h0040);
        check("jump_incr", incr_pc, 0);
        check("jump_pend", pc_pend, 0);
        tick();
        check("jump_after_incr", incr_pc, 0);
        check("jump_after_we", we, 0);

        // Reset in the cycle after a write to R5, with increments pending.
        hold = 1'b1; pc_inc_req = 1'b1;
        repeat (2) tick();
        hold = 1'b0;
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 16'h5555;
        tick();
        req1_valid = 1'b0; pc_inc_req = 1'b0;
        check("rmid_we_pre", we, 1);
        reset = 1'b0;
        #1;
        check("rmid_we_drop", we, 0);
        check("rmid_pend_drop", pc_pend, 0);
        check("rmid_incr_drop", incr_pc, 0);
        tick();
        reset = 1'b1;
        tick();
        check("rmid_we_post", we, 0);
        check("rmid_pend_post", pc_pend, 0);
        tick();
        check("rmid_we_post2", we, 0);
        check("rmid_incr_post2", incr_pc, 0);
        check("rmid_regws_post2", regws, 0);

        // Randomized traffic; requesters keep a request stable until it is taken.
        hold_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            x0 = req0_valid && req0_ready;
            x1 = req1_valid && req1_ready;
            tick();
            if (cyc == 1500) reset = 1'b0;
            if (cyc == 1502) reset = 1'b1;
            if (!req0_valid || x0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_addr  = 3'($urandom_range(0, 7));
                req0_data  = 16'($urandom);
            end
            if (!req1_valid || x1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_addr  = 3'($urandom_range(0, 7));
                req1_data  = 16'($urandom);
            end
            if (hold_left > 0) begin
                hold_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                hold_left = int'($urandom_range(1, 6));
            end
            hold       = (hold_left > 0);
            pc_inc_req = ($urandom_range(0, 2) == 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; hold = 1'b0; pc_inc_req = 1'b0;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_arb.md
REGFILE_ARB -- requirements
Module: regfile_arb

Interface
REQ-001 SHALL declare parameter DW, default 16, the register data width.
REQ-002 SHALL declare parameter PEND_MAX, default 3, the saturation limit of the deferred PC-increment count.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports req0_valid / req1_valid  in  1  write request from requester 0 / 1.
REQ-006 SHALL have ports req0_addr / req1_addr  in  3  target register index.
REQ-007 SHALL have ports req0_data / req1_data  in  DW  write data.
REQ-008 SHALL have ports req0_ready / req1_ready  out  1  combinational grant; a transfer occurs on a rising edge with valid && ready.
REQ-009 SHALL have port hold  in  1  stall: no grants and no PC increments while 1.
REQ-010 SHALL have port pc_inc_req  in  1  request one PC (R7) increment this cycle.
REQ-011 SHALL have ports regws  out  3, regw  out  DW, we  out  1, incr_pc  out  1  registered drive of the register-file write port.
REQ-012 SHALL have port pc_pend  out  2  current deferred-increment count.

Function
REQ-013 Arbitration: with hold=0, if exactly one valid is high, that requester's ready is 1; if both are high, the requester not granted most recently gets ready; the other's ready is 0.
REQ-014 Round-robin pointer SHALL update only on a completed transfer; after reset requester 0 has priority.
REQ-015 With hold=1 both ready outputs SHALL be 0 regardless of valid.
REQ-016 Requesters SHALL hold valid, addr and data stable until ready; the block need not tolerate changes before the transfer.
REQ-017 Latency: a transfer at edge N SHALL drive we=1, regws=addr, regw=data for exactly the cycle after edge N (the register file commits on the following falling edge); otherwise we=0 and regws/regw SHALL keep their last values.
REQ-018 A transfer with addr=0 SHALL be accepted (ready=1, RR pointer advances) but SHALL produce we=0.
REQ-019 PC increment issue: with hold=0 and no R7 write being transferred, incr_pc SHALL be 1 in the next cycle if pc_inc_req=1 or pc_pend>0; when both hold, one increment is issued and the other is retained in pc_pend.
REQ-020 Deferral: pc_inc_req=1 while hold=1 SHALL increment pc_pend, saturating at PEND_MAX; further requests are dropped silently.
REQ-021 Drain: after hold falls, pending increments SHALL issue one per cycle (incr_pc=1 for pc_pend consecutive cycles), with a same-cycle pc_inc_req added to the count (saturating).
REQ-022 A transfer to R7 (addr=7) SHALL clear pc_pend to 0 and suppress incr_pc for that issue cycle, including any same-cycle pc_inc_req (the jump overrides increments).
REQ-023 we=1 with regws=7 and incr_pc=1 SHALL never be driven in the same cycle.
REQ-024 incr_pc SHALL never be 1 while hold was 1 at the preceding edge.

Reset
REQ-025 While reset=0: ready outputs 0, we=0, incr_pc=0, regws=0, regw=0, pc_pend=0, RR pointer = requester 0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard any issued-but-not-driven write and all pending increments; no write is replayed after reset release.
REQ-027 The first grant SHALL be possible at the first rising edge after reset rises.

Structure
REQ-028 A shared package regfile_pkg SHALL hold REG_ZERO=3'd0, REG_PC=3'd7, the register-index width 3 and a write-request struct {addr, data}.
REQ-029 The two-way round-robin grant SHALL be a sub-module rr_arb2 (inputs req[1:0], advance; output gnt[1:0]); the PC-pending counter and output registers stay in regfile_arb.

Verification
REQ-030 Single write: req0 valid, addr=3, data=16'h1234 -> req0_ready=1 same cycle; next cycle we=1, regws=3, regw=16'h1234; cycle after we=0.
REQ-031 Contention: both valid for 4 cycles, addr 1 and 2 -> grants alternate 0,1,0,1; we pulses carry regws 1,2,1,2.
REQ-032 Zero write: req1 addr=0, data=16'hFFFF -> req1_ready=1, we stays 0; then both valid -> req0 granted (pointer advanced).
REQ-033 Hold/drain: hold=1, pc_inc_req high for 5 cycles -> pc_pend=3, incr_pc=0; release hold, pc_inc_req=0 -> incr_pc=1 for exactly 3 cycles, pc_pend counts 2,1,0.
REQ-034 Jump: pc_pend=2, transfer addr=7, data=16'h0040 with pc_inc_req=1 -> next cycle we=1, regws=7, incr_pc=0; pc_pend=0.
REQ-035 Reset mid-operation: reset=0 in the cycle after a transfer to addr=5 -> we falls to 0 immediately; after release, no write to R5 and pc_pend=0.
